sequential_multiplier_param: RTL and testbench
==============================================

Name: sequential_multiplier_param

Overview:
Parametrised successor to the 4-bit shift-add sequential multiplier. It multiplies two WIDTH-bit operands with one shift-add step per clock. It adds a signed (two's complement) mode, optional early termination when the remaining multiplier bits are zero, a busy flag, and armed-start protection. It is a compute leaf under the SoC datapath and uses the same start/done handshake as the 4-bit unit.

Parameters:
WIDTH, 8, operand width in bits (≥2); result is 2*WIDTH bits.
EARLY_TERM, 1, 1 = stop as soon as remaining multiplier magnitude is zero; 0 = always WIDTH CALC cycles.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a multiplication; sampled on rising edge.
signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; latched at accept.
A_in  input  WIDTH  multiplicand; latched at accept.
B_in  input  WIDTH  multiplier; latched at accept.
result  output  2*WIDTH  product; valid while done=1; holds until the next completion or reset.
done  output  1  high in DONE state.
busy  output  1  high in CALC state.

Behaviour:
- Reset (rst=1 at rising edge, any state, including mid-CALC): state=IDLE; result=0, done=0, busy=0; accumulator, counter and operand registers cleared; armed=0. Reset has priority over all other inputs.
- armed flag: set on any edge where start=0. A start is accepted only when start=1 AND armed=1 AND state is IDLE or DONE. Accept clears armed. A start held high therefore triggers exactly one operation.
- States:
  - IDLE: done=0, busy=0. Accept → CALC.
  - CALC: busy=1, done=0. start is ignored; operands are not re-sampled.
  - DONE: done=1. Accept → CALC (done drops the next cycle; result keeps its old value until the new completion).
- Accept edge (cycle 0):
  - latch sign flag neg = signed_mode & (A_in[MSB] ^ B_in[MSB]).
  - latch magA/magB = absolute values when signed_mode=1, raw values otherwise.
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH bits unsigned.
  - accumulator=0, counter=0.
- CALC step (each edge):
  - if magB[0], accumulator += magA << counter (2*WIDTH-bit arithmetic; cannot overflow).
  - magB >>= 1; counter += 1.
- Exit CALC after the step where counter reaches WIDTH, or (EARLY_TERM=1) where the shifted magB == 0.
  - Minimum one CALC cycle, including B=0.
  - k = number of CALC cycles = max(1, index of highest set bit of magB + 1) with EARLY_TERM=1; WIDTH otherwise.
- On the exit edge: result = neg ? −accumulator : accumulator (2*WIDTH-bit two's complement; −0 = 0). State → DONE.
- Latency: done first visible k+1 rising edges after the accept edge.
- Operand changes on A_in/B_in/signed_mode after the accept edge have no effect.

Test Plan:
- WIDTH=8 unsigned, 255×255 with a single start pulse → busy for 8 cycles; done at accept+9; result=16'hFE01 (65025).
- WIDTH=8 signed: −3×5 → result=16'hFFF1 (−15). −128×−128 → result=16'h4000 (16384). 127×−128 → 16'hC080 (−16256).
- Early termination, EARLY_TERM=1, unsigned: 200×1 → done at accept+2, result=200. 15×0 → done at accept+2, result=0. Same operands with EARLY_TERM=0 → done at accept+9.
- Reset mid-flight: accept 15×2, assert rst for one edge 3 cycles later → next cycle done=0, busy=0, result=0; a fresh 3×3 then completes with result=9.
- Stuck start: hold start=1 through 2×4 → result=8, done stays 1 for ≥5 further cycles with no restart. Release then re-pulse start with 3×3 → done drops, then completes with result=9.
- Start during CALC: pulse start with new operands mid-CALC → ignored; the original product completes. Back-to-back: start asserted in DONE the cycle after done → new product with correct latency.

Source files
------------

// File: rtl/sequential_multiplier_param.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Signed mode multiplies magnitudes and negates the product at the end.
module sequential_multiplier_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A_in,
  input  logic [WIDTH-1:0]     B_in,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  // Handshake: a start is accepted on a rising edge where start=1, the unit is
  // IDLE or DONE, and start was seen low on some earlier edge (armed). done stays
  // high in DONE until the next accept; busy is high for every CALC cycle.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 armed;
  logic                 neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic                 accept;
  logic                 last_step;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mag_b_shr;
  logic [CW-1:0]        cnt_inc;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  assign accept = start && armed && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    acc_sum   = acc + (mag_b[0] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0);
    mag_b_shr = mag_b >> 1;
    cnt_inc   = cnt + CW'(1);
    last_step = (cnt_inc == CW'(WIDTH)) || (EARLY_TERM && (mag_b_shr == '0));
    // The most negative operand negates to itself, which reads correctly as unsigned.
    abs_a     = (signed_mode && A_in[WIDTH-1]) ? -A_in : A_in;
    abs_b     = (signed_mode && B_in[WIDTH-1]) ? -B_in : B_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CALC;
      S_CALC:  if (last_step) state_next = S_DONE;
      S_DONE:  if (accept) state_next = S_CALC;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b0;
      neg    <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        armed <= 1'b0;
      end else if (!start) begin
        armed <= 1'b1;
      end

      if (accept) begin
        neg   <= signed_mode & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
        mag_a <= abs_a;
        mag_b <= abs_b;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == S_CALC) begin
        acc   <= acc_sum;
        mag_b <= mag_b_shr;
        cnt   <= cnt_inc;
        if (last_step) begin
          result <= neg ? -acc_sum : acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_multiplier_param.sv
// Directed bench for sequential_multiplier_param: one early-terminating and one
// full-length instance share the same stimulus and are checked side by side.
module tb_sequential_multiplier_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  A_in;
  logic [7:0]  B_in;
  logic [15:0] res_et;
  logic [15:0] res_full;
  logic        done_et;
  logic        done_full;
  logic        busy_et;
  logic        busy_full;

  int          checks;
  int          errors;
  logic [15:0] last_res;

  sequential_multiplier_param #(.WIDTH(8), .EARLY_TERM(1'b1)) u_et (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A_in(A_in), .B_in(B_in), .result(res_et), .done(done_et), .busy(busy_et)
  );

  sequential_multiplier_param #(.WIDTH(8), .EARLY_TERM(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A_in(A_in), .B_in(B_in), .result(res_full), .done(done_full), .busy(busy_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A_in = '0; B_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 6;
    if (res_et !== 16'h0000)  begin errors++; $display("FAIL reset_res_et: got %h want 0000", res_et); end
    if (res_full !== 16'h0000) begin errors++; $display("FAIL reset_res_full: got %h want 0000", res_full); end
    if (done_et !== 1'b0)     begin errors++; $display("FAIL reset_done_et: got %b want 0", done_et); end
    if (done_full !== 1'b0)   begin errors++; $display("FAIL reset_done_full: got %b want 0", done_full); end
    if (busy_et !== 1'b0)     begin errors++; $display("FAIL reset_busy_et: got %b want 0", busy_et); end
    if (busy_full !== 1'b0)   begin errors++; $display("FAIL reset_busy_full: got %b want 0", busy_full); end
    last_res = 16'h0000;
  endtask

  // Accept one operation and follow both instances to completion.
  // exp_k: CALC cycles of the early-terminating instance (full instance always 8).
  task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, input logic [15:0] exp_res, input int exp_k,
                         input bit b2b, input bit mid_pulse);
    int lat_et;
    int lat_full;
    int bc_et;
    int bc_full;
    if (!b2b) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    A_in = a; B_in = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A_in = ~a; B_in = ~b; signed_mode = ~sm;
    checks += 4;
    if (done_et !== 1'b0)     begin errors++; $display("FAIL %s_done_drop_et: got %b want 0", name, done_et); end
    if (done_full !== 1'b0)   begin errors++; $display("FAIL %s_done_drop_full: got %b want 0", name, done_full); end
    if (res_et !== last_res)  begin errors++; $display("FAIL %s_hold_res_et: got %h want %h", name, res_et, last_res); end
    if (res_full !== last_res) begin errors++; $display("FAIL %s_hold_res_full: got %h want %h", name, res_full, last_res); end
    lat_et = 0; lat_full = 0;
    bc_et = busy_et ? 1 : 0;
    bc_full = busy_full ? 1 : 0;
    for (int i = 1; i <= 20 && (lat_et == 0 || lat_full == 0); i++) begin
      if (mid_pulse && i == 3) begin A_in = 8'h07; B_in = 8'h07; start = 1'b1; end
      if (mid_pulse && i == 4) start = 1'b0;
      @(posedge clk);
      #1;
      if (busy_et) bc_et++;
      if (busy_full) bc_full++;
      if (done_et && lat_et == 0) lat_et = i + 1;
      if (done_full && lat_full == 0) lat_full = i + 1;
    end
    checks += 6;
    if (lat_et != exp_k + 1)  begin errors++; $display("FAIL %s_lat_et: got %0d want %0d", name, lat_et, exp_k + 1); end
    if (lat_full != 9)        begin errors++; $display("FAIL %s_lat_full: got %0d want 9", name, lat_full); end
    if (bc_et != exp_k)       begin errors++; $display("FAIL %s_busy_et: got %0d want %0d", name, bc_et, exp_k); end
    if (bc_full != 8)         begin errors++; $display("FAIL %s_busy_full: got %0d want 8", name, bc_full); end
    if (res_et !== exp_res)   begin errors++; $display("FAIL %s_res_et: got %h want %h", name, res_et, exp_res); end
    if (res_full !== exp_res) begin errors++; $display("FAIL %s_res_full: got %h want %h", name, res_full, exp_res); end
    last_res = exp_res;
  endtask

  task automatic test_reset_mid_flight();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_in = 8'd15; B_in = 8'd2; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 6;
    if (res_et !== 16'h0000)  begin errors++; $display("FAIL midrst_res_et: got %h want 0000", res_et); end
    if (res_full !== 16'h0000) begin errors++; $display("FAIL midrst_res_full: got %h want 0000", res_full); end
    if (done_et !== 1'b0)     begin errors++; $display("FAIL midrst_done_et: got %b want 0", done_et); end
    if (done_full !== 1'b0)   begin errors++; $display("FAIL midrst_done_full: got %b want 0", done_full); end
    if (busy_et !== 1'b0)     begin errors++; $display("FAIL midrst_busy_et: got %b want 0", busy_et); end
    if (busy_full !== 1'b0)   begin errors++; $display("FAIL midrst_busy_full: got %b want 0", busy_full); end
    last_res = 16'h0000;
    test_op("after_rst_3x3", 8'd3, 8'd3, 1'b0, 16'd9, 2, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_start();
    int lat_et;
    int lat_full;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_in = 8'd2; B_in = 8'd4; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    lat_et = 0; lat_full = 0;
    for (int i = 1; i <= 20 && (lat_et == 0 || lat_full == 0); i++) begin
      @(posedge clk);
      #1;
      if (done_et && lat_et == 0) lat_et = i + 1;
      if (done_full && lat_full == 0) lat_full = i + 1;
    end
    checks += 4;
    if (lat_et != 4)          begin errors++; $display("FAIL stuck_lat_et: got %0d want 4", lat_et); end
    if (lat_full != 9)        begin errors++; $display("FAIL stuck_lat_full: got %0d want 9", lat_full); end
    if (res_et !== 16'd8)     begin errors++; $display("FAIL stuck_res_et: got %h want 0008", res_et); end
    if (res_full !== 16'd8)   begin errors++; $display("FAIL stuck_res_full: got %h want 0008", res_full); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks += 3;
      if (done_et !== 1'b1)   begin errors++; $display("FAIL stuck_hold_done_et[%0d]: got %b want 1", i, done_et); end
      if (busy_et !== 1'b0)   begin errors++; $display("FAIL stuck_hold_busy_et[%0d]: got %b want 0", i, busy_et); end
      if (done_full !== 1'b1) begin errors++; $display("FAIL stuck_hold_done_full[%0d]: got %b want 1", i, done_full); end
    end
    start = 1'b0;
    last_res = 16'd8;
    test_op("rearm_3x3", 8'd3, 8'd3, 1'b0, 16'd9, 2, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_res = '0;
    test_reset();
    test_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 1'b0, 1'b0);
    test_op("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1, 3, 1'b0, 1'b0);
    test_op("s_5xm3",   8'h05, 8'hFD, 1'b1, 16'hFFF1, 2, 1'b0, 1'b0);
    test_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000, 8, 1'b0, 1'b0);
    test_op("b2b_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080, 8, 1'b1, 1'b0);
    test_op("u200x1",   8'd200, 8'd1, 1'b0, 16'h00C8, 1, 1'b0, 1'b0);
    test_op("u15x0",    8'd15,  8'd0, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
    test_op("mid_calc_start", 8'd10, 8'h81, 1'b0, 16'h050A, 8, 1'b0, 1'b1);
    test_op("b2b_u3x7", 8'd3, 8'd7, 1'b0, 16'h0015, 3, 1'b1, 1'b0);
    test_reset_mid_flight();
    test_stuck_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
